// File: rtl/fp_mul_norm_round_if.sv
// Handshake and data bundle between the Wallace-tree stage, the post-multiply
// normalize/round stage and its consumer.
interface fp_mul_norm_round_if #(
   parameter int EXP_W = 10
);
   logic             in_valid;
   logic             in_ready;
   logic             in_sign;
   logic [EXP_W-1:0] in_exp;
   logic [47:0]      in_prod;
   logic             in_nan;
   logic             in_inf;
   logic             in_zero;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_result;
   logic             out_overflow;
   logic             out_underflow;
   logic             out_inexact;

   modport master (
      output in_valid, in_sign, in_exp, in_prod, in_nan, in_inf, in_zero, out_ready,
      input  in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
   );

   modport slave (
      input  in_valid, in_sign, in_exp, in_prod, in_nan, in_inf, in_zero, out_ready,
      output in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
   );
endinterface

// File: rtl/fp_mul_norm_round.sv
// Post-multiply stage of the binary32 multiplier: S1 normalizes the 48-bit
// product, S2 rounds to nearest-even, range-checks and packs the result.
module fp_mul_norm_round #(
   parameter int EXP_W = 10,
   parameter int BIAS  = 127
) (
   input logic                clk,
   input logic                rst_n,
   fp_mul_norm_round_if.slave bus
);
   localparam int EW = EXP_W + 1;
   localparam logic signed [EW-1:0] E_MAX  = EW'(2 * BIAS + 1);
   localparam logic signed [EW-1:0] E_ZERO = '0;

   logic adv1;
   logic adv2;

   logic                 s1_valid_q;
   logic                 s1_sign_q;
   logic signed [EW-1:0] s1_exp_q;
   logic [22:0]          s1_mant_q;
   logic                 s1_g_q;
   logic                 s1_rs_q;
   logic                 s1_nan_q;
   logic                 s1_inf_q;
   logic                 s1_zero_q;

   logic        out_valid_q;
   logic [31:0] out_result_q;
   logic        out_ovf_q;
   logic        out_unf_q;
   logic        out_inx_q;

   assign adv2        = !out_valid_q | bus.out_ready;
   assign adv1        = !s1_valid_q | adv2;
   assign bus.in_ready = adv1;

   // S1: normalize so the hidden bit is dropped; round|sticky are merged
   // because S2 only needs their OR.
   logic signed [EW-1:0] s1_exp_d;
   logic [22:0]          s1_mant_d;
   logic                 s1_g_d;
   logic                 s1_rs_d;
   logic                 s1_zero_d;

   always_comb begin
      s1_exp_d  = {bus.in_exp[EXP_W-1], bus.in_exp};
      s1_mant_d = bus.in_prod[45:23];
      s1_g_d    = bus.in_prod[22];
      s1_rs_d   = bus.in_prod[21] | (|bus.in_prod[20:0]);
      s1_zero_d = bus.in_zero | (bus.in_prod == 48'd0);
      if (bus.in_prod[47]) begin
         s1_exp_d  = {bus.in_exp[EXP_W-1], bus.in_exp} + EW'(1);
         s1_mant_d = bus.in_prod[46:24];
         s1_g_d    = bus.in_prod[23];
         s1_rs_d   = bus.in_prod[22] | (|bus.in_prod[21:0]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_sign_q  <= 1'b0;
         s1_exp_q   <= '0;
         s1_mant_q  <= '0;
         s1_g_q     <= 1'b0;
         s1_rs_q    <= 1'b0;
         s1_nan_q   <= 1'b0;
         s1_inf_q   <= 1'b0;
         s1_zero_q  <= 1'b0;
      end else begin
         if (adv1) s1_valid_q <= bus.in_valid;
         if (adv1 && bus.in_valid) begin
            s1_sign_q <= bus.in_sign;
            s1_exp_q  <= s1_exp_d;
            s1_mant_q <= s1_mant_d;
            s1_g_q    <= s1_g_d;
            s1_rs_q   <= s1_rs_d;
            s1_nan_q  <= bus.in_nan;
            s1_inf_q  <= bus.in_inf;
            s1_zero_q <= s1_zero_d;
         end
      end
   end

   // S2: a carry out of the 23-bit fraction leaves it all zero, so only the
   // exponent needs the extra increment.
   logic                 round_up;
   logic [23:0]          r_mant;
   logic signed [EW-1:0] r_exp;
   logic [31:0]          res_d;
   logic                 ovf_d;
   logic                 unf_d;
   logic                 inx_d;

   always_comb begin
      round_up = s1_g_q & (s1_rs_q | s1_mant_q[0]);
      r_mant   = {1'b0, s1_mant_q} + 24'(round_up);
      r_exp    = s1_exp_q + EW'(r_mant[23]);
      res_d    = {s1_sign_q, r_exp[7:0], r_mant[22:0]};
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
      inx_d    = s1_g_q | s1_rs_q;
      if (s1_nan_q) begin
         res_d = 32'h7FC0_0000;
         inx_d = 1'b0;
      end else if (s1_inf_q) begin
         res_d = {s1_sign_q, 8'hFF, 23'd0};
         inx_d = 1'b0;
      end else if (s1_zero_q) begin
         res_d = {s1_sign_q, 31'd0};
         inx_d = 1'b0;
      end else if (r_exp >= E_MAX) begin
         res_d = {s1_sign_q, 8'hFF, 23'd0};
         ovf_d = 1'b1;
         inx_d = 1'b1;
      end else if (r_exp <= E_ZERO) begin
         res_d = {s1_sign_q, 31'd0};
         unf_d = 1'b1;
         inx_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_ovf_q    <= 1'b0;
         out_unf_q    <= 1'b0;
         out_inx_q    <= 1'b0;
      end else begin
         if (adv2) out_valid_q <= s1_valid_q;
         if (adv2 && s1_valid_q) begin
            out_result_q <= res_d;
            out_ovf_q    <= ovf_d;
            out_unf_q    <= unf_d;
            out_inx_q    <= inx_d;
         end
      end
   end

   assign bus.out_valid     = out_valid_q;
   assign bus.out_result    = out_result_q;
   assign bus.out_overflow  = out_ovf_q;
   assign bus.out_underflow = out_unf_q;
   assign bus.out_inexact   = out_inx_q;
endmodule

// File: tb/tb_fp_mul_norm_round.sv
// Scoreboard bench for fp_mul_norm_round: expected results come from a
// value-level rounding model and are checked by an independent monitor.
module tb_fp_mul_norm_round;
   typedef struct {
      logic [31:0] res;
      bit          ovf;
      bit          unf;
      bit          inx;
      int          acc;
   } exp_t;

   logic clk;
   logic rst_n;
   fp_mul_norm_round_if #(.EXP_W(10)) bus ();

   fp_mul_norm_round #(.EXP_W(10), .BIAS(127)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   acc_cnt = 0;
   bit   chk_lat = 0;
   bit   rand_rdy = 0;
   exp_t sb_q[$];
   logic [31:0] last_res;
   bit   last_ovf, last_unf, last_inx;
   bit   held_v = 0;
   logic [34:0] held;

   initial clk = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, req);
      end
   endfunction

   // Reference: treat the product as an integer, keep the top 24 bits and
   // round the discarded remainder against exactly one half ULP.
   function automatic exp_t model(bit s, int ein, longint unsigned p, bit nan, bit inf, bit zero);
      exp_t x;
      int sh, e;
      longint unsigned m, rem, half;
      x = '{res: 32'd0, ovf: 0, unf: 0, inx: 0, acc: 0};
      if (nan) x.res = 32'h7FC00000;
      else if (inf) x.res = {s, 8'hFF, 23'd0};
      else if (zero || p == 0) x.res = {s, 31'd0};
      else begin
         sh   = p[47] ? 24 : 23;
         e    = ein + (p[47] ? 1 : 0);
         m    = p >> sh;
         rem  = p & ((64'd1 << sh) - 1);
         half = 64'd1 << (sh - 1);
         x.inx = (rem != 0);
         if (rem > half || (rem == half && (m % 2) == 1)) m++;
         if (m == (64'd1 << 24)) begin
            m = 64'd1 << 23;
            e++;
         end
         if (e >= 255) begin
            x.res = {s, 8'hFF, 23'd0}; x.ovf = 1; x.inx = 1;
         end else if (e <= 0) begin
            x.res = {s, 31'd0}; x.unf = 1; x.inx = 1;
         end else
            x.res = {s, 8'(e), 23'(m)};
      end
      return x;
   endfunction

   // Stimulus side of the scoreboard: every accepted input pushes its expectation.
   always @(negedge clk) begin
      exp_t x;
      if (rst_n && bus.in_valid && bus.in_ready) begin
         x = model(bus.in_sign, int'($signed(bus.in_exp)), 64'(bus.in_prod),
                   bus.in_nan, bus.in_inf, bus.in_zero);
         x.acc = cyc + 1;
         sb_q.push_back(x);
         acc_cnt++;
      end
   end

   // Monitor: pops on every output transfer and checks hold-stability under stall.
   always @(negedge clk) begin
      exp_t x;
      if (rst_n && held_v && bus.out_valid)
         chk("stall_hold", {bus.out_result, bus.out_overflow, bus.out_underflow, bus.out_inexact}, held);
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (sb_q.size() == 0) chk("unexpected_output", 1, 0);
         else begin
            x = sb_q.pop_front();
            chk("result", bus.out_result, x.res);
            chk("flags", {bus.out_overflow, bus.out_underflow, bus.out_inexact}, {x.ovf, x.unf, x.inx});
            if (chk_lat) chk("latency", cyc + 1 - x.acc, 2);
         end
         last_res = bus.out_result;
         last_ovf = bus.out_overflow;
         last_unf = bus.out_underflow;
         last_inx = bus.out_inexact;
      end
      held_v = rst_n && bus.out_valid && !bus.out_ready;
      held   = {bus.out_result, bus.out_overflow, bus.out_underflow, bus.out_inexact};
   end

   always @(posedge clk) begin
      if (rand_rdy) begin
         #1;
         if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Call at posedge+#1; returns at posedge+#1 after the accepting edge.
   task automatic send(input bit s, input logic [9:0] e, input logic [47:0] p,
                       input bit nan, input bit inf, input bit zero);
      int n;
      bus.in_valid = 1; bus.in_sign = s; bus.in_exp = e; bus.in_prod = p;
      bus.in_nan = nan; bus.in_inf = inf; bus.in_zero = zero;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.in_ready && n < 200);
      if (!bus.in_ready) chk("send_timeout", 0, 1);
      @(posedge clk); #1;
      bus.in_valid = 0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb_q.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk); #1;
      chk("drain", sb_q.size(), 0);
   endtask

   task automatic dir_vec(string nm, bit s, logic [9:0] e, logic [47:0] p,
                          bit nan, bit inf, bit zero, logic [31:0] r, bit o, bit u, bit x);
      send(s, e, p, nan, inf, zero);
      wait_drain();
      chk(nm, {last_res, last_ovf, last_unf, last_inx}, {r, o, u, x});
   endtask

   task automatic gen_rand(output bit s, output logic [9:0] e, output logic [47:0] p,
                           output bit nan, output bit inf, output bit zero);
      longint unsigned ma, mb;
      int sel;
      s  = 1'($urandom_range(0, 1));
      ma = 64'h800000 | 64'($urandom_range(0, 24'h7FFFFF));
      mb = 64'h800000 | 64'($urandom_range(0, 24'h7FFFFF));
      sel = $urandom_range(0, 9);
      if (sel == 0) p = 48'((ma << 23) | 64'h400000);
      else if (sel == 1) p = 48'((64'hFFFFFF << 23) | 64'h400000);
      else if (sel == 2) p = 48'd0;
      else p = 48'(ma * mb);
      sel = $urandom_range(0, 9);
      if (sel < 6) e = 10'($urandom_range(1, 253));
      else if (sel == 6) e = 10'($urandom_range(250, 300));
      else if (sel == 7) e = 10'(int'($urandom_range(0, 32)) - 30);
      else e = 10'($urandom_range(0, 1023));
      sel = $urandom_range(0, 15);
      nan  = (sel == 0);
      inf  = (sel <= 1) ? 1'($urandom_range(0, 1)) | (sel == 1) : 1'b0;
      zero = (sel <= 2) ? 1'($urandom_range(0, 1)) | (sel == 2) : 1'b0;
   endtask

   initial begin
      bit s, nan, inf, zero;
      logic [9:0] e;
      logic [47:0] p;
      int base;

      rst_n = 0;
      bus.in_valid = 0; bus.in_sign = 0; bus.in_exp = '0; bus.in_prod = '0;
      bus.in_nan = 0; bus.in_inf = 0; bus.in_zero = 0; bus.out_ready = 1;
      #1;
      chk("reset_out_valid", bus.out_valid, 0);
      chk("reset_out_result", bus.out_result, 0);
      chk("reset_flags", {bus.out_overflow, bus.out_underflow, bus.out_inexact}, 0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1;
      #1 chk("reset_in_ready", bus.in_ready, 1);
      @(posedge clk); #1;

      chk_lat = 1;
      dir_vec("one_x_one",   0, 10'd127, 48'h400000000000, 0, 0, 0, 32'h3F800000, 0, 0, 0);
      dir_vec("1p5_sq",      0, 10'd127, 48'h900000000000, 0, 0, 0, 32'h40100000, 0, 0, 0);
      // exact halfway: guard set, nothing below, even mantissa stays
      dir_vec("tie_even",    0, 10'd127, 48'h400000400000, 0, 0, 0, 32'h3F800000, 0, 0, 1);
      dir_vec("tie_odd",     0, 10'd127, 48'h400000C00000, 0, 0, 0, 32'h3F800002, 0, 0, 1);
      dir_vec("round_carry", 0, 10'd127, 48'h7FFFFFC00000, 0, 0, 0, 32'h40000000, 0, 0, 1);
      dir_vec("overflow",    1, 10'd254, 48'h800000000000, 0, 0, 0, 32'hFF800000, 1, 0, 1);
      dir_vec("ovf_by_carry",0, 10'd254, 48'h7FFFFFC00000, 0, 0, 0, 32'h7F800000, 1, 0, 1);
      dir_vec("max_normal",  0, 10'd253, 48'h800000000000, 0, 0, 0, 32'h7F000000, 0, 0, 0);
      dir_vec("underflow",   0, 10'd0,   48'h400000000000, 0, 0, 0, 32'h00000000, 0, 1, 1);
      dir_vec("neg_exp",     1, 10'h3FF, 48'h800000000000, 0, 0, 0, 32'h80000000, 0, 1, 1);
      dir_vec("nan",         1, 10'd127, 48'h400000000000, 1, 1, 1, 32'h7FC00000, 0, 0, 0);
      dir_vec("inf",         1, 10'd300, 48'h400000000000, 0, 1, 1, 32'hFF800000, 0, 0, 0);
      dir_vec("zero_flag",   1, 10'd127, 48'h400000400000, 0, 0, 1, 32'h80000000, 0, 0, 0);
      dir_vec("zero_prod",   0, 10'd127, 48'h000000000000, 0, 0, 0, 32'h00000000, 0, 0, 0);
      chk_lat = 0;

      base = acc_cnt;
      fork
         begin
            @(posedge clk); #1 bus.out_ready = 0;
            repeat (5) @(posedge clk);
            #1 bus.out_ready = 1;
         end
         begin
            for (int i = 0; i < 4; i++) begin
               gen_rand(s, e, p, nan, inf, zero);
               send(s, e, p, nan, inf, zero);
            end
         end
         begin
            repeat (4) @(negedge clk);
            chk("bp_accepted", acc_cnt - base, 2);
            chk("bp_in_ready", bus.in_ready, 0);
         end
      join
      wait_drain();
      chk("bp_all_out", acc_cnt - base, 4);

      bus.out_ready = 0;
      send(0, 10'd127, 48'h900000000000, 0, 0, 0);
      send(1, 10'd127, 48'h400000000000, 0, 0, 0);
      rst_n = 0;
      #1;
      chk("midrst_out_valid", bus.out_valid, 0);
      chk("midrst_out_result", bus.out_result, 0);
      sb_q.delete();
      #3 rst_n = 1;
      bus.out_ready = 1;
      @(posedge clk); #1;
      chk_lat = 1;
      dir_vec("after_reset", 0, 10'd127, 48'h400000000000, 0, 0, 0, 32'h3F800000, 0, 0, 0);
      chk_lat = 0;

      rand_rdy = 1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
         end
         gen_rand(s, e, p, nan, inf, zero);
         send(s, e, p, nan, inf, zero);
      end
      rand_rdy = 0;
      @(posedge clk); #2;
      bus.out_ready = 1;
      wait_drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
